// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte I2C master sequencer (START, addr, R/W, ACK, data, ACK, STOP)
// Ports: clk/rst (sync, active-high); start_req/addr/rw/wr_data host command, accepted when idle;
//        rd_data last read byte; busy/done/nack host status; SCL/SDA_out open-drain drives
//        (1 = release); SDA_in resolved bus data; SCL_in resolved bus clock.
// Option: define I2C_CLK_STRETCH_EN to hold the quarter counter in q2 while SCL_in is low.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_req,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       SCL,
    output logic       SDA_out,
    input  logic       SDA_in,
    input  logic       SCL_in
);
`ifdef I2C_CLK_STRETCH_EN
    localparam bit STRETCH = 1'b1;
`else
    localparam bit STRETCH = 1'b0;
`endif
    localparam int QW = $clog2(CLK_DIV) + 1;

    typedef enum logic [2:0] {IDLE, START, ADDR, RW, ADDR_ACK, DATA, DATA_ACK, STOP} state_t;

    state_t        state, state_n;
    logic [QW-1:0] qcnt;
    logic [1:0]    quarter;
    logic [2:0]    bit_cnt;
    logic [6:0]    addr_r;
    logic          rw_r;
    logic [7:0]    wr_r;
    logic [7:0]    sh;
    logic          stall, q_end, bit_end, sample;

    // A stretching slave holds SCL low while we have released it in q2.
    assign stall   = STRETCH && quarter == 2'd2 && !SCL_in;
    assign q_end   = !stall && qcnt == QW'(CLK_DIV - 1);
    assign bit_end = q_end && quarter == 2'd3;
    assign sample  = q_end && quarter == 2'd2;
    assign busy    = state != IDLE;

    always_comb begin
        state_n = state;
        SCL     = quarter[1];
        SDA_out = 1'b1;
        case (state)
            IDLE: begin
                SCL = 1'b1;
                // the done cycle itself never accepts a new command
                if (start_req && !done) state_n = START;
            end
            START: begin
                SCL     = 1'b1;
                SDA_out = !quarter[1];
                if (bit_end) state_n = ADDR;
            end
            ADDR: begin
                SDA_out = addr_r[bit_cnt];
                if (bit_end && bit_cnt == 3'd0) state_n = RW;
            end
            RW: begin
                SDA_out = rw_r;
                if (bit_end) state_n = ADDR_ACK;
            end
            ADDR_ACK: if (bit_end) state_n = nack ? STOP : DATA;
            DATA: begin
                SDA_out = rw_r | wr_r[bit_cnt];
                if (bit_end && bit_cnt == 3'd0) state_n = DATA_ACK;
            end
            // released SDA doubles as the master NACK that ends a single-byte read
            DATA_ACK: if (bit_end) state_n = STOP;
            STOP: begin
                SCL     = quarter != 2'd0;
                SDA_out = quarter[1];
                if (bit_end) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            qcnt    <= '0;
            quarter <= '0;
            bit_cnt <= '0;
            nack    <= 1'b0;
            done    <= 1'b0;
            rd_data <= '0;
            sh      <= '0;
            addr_r  <= '0;
            rw_r    <= 1'b0;
            wr_r    <= '0;
        end else begin
            state <= state_n;
            done  <= state == STOP && bit_end;
            if (state == IDLE) begin
                if (state_n == START) begin
                    addr_r <= addr;
                    rw_r   <= rw;
                    wr_r   <= wr_data;
                    nack   <= 1'b0;
                end
            end else if (!stall) begin
                qcnt <= q_end ? '0 : qcnt + 1'b1;
                if (q_end) quarter <= quarter + 2'd1;
            end
            if (bit_end) bit_cnt <= state == START ? 3'd6 : state == ADDR_ACK ? 3'd7 : bit_cnt - 3'd1;
            if (sample && SDA_in && (state == ADDR_ACK || (state == DATA_ACK && !rw_r))) nack <= 1'b1;
            if (sample && state == DATA) sh <= {sh[6:0], SDA_in};
            if (bit_end && state == DATA_ACK && rw_r) rd_data <= sh;
        end
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: directed + random transactions against a bus-level slave and reference model
module tb_i2c_master_ctrl;
    localparam int D = 4;
    localparam logic [6:0] SLV = 7'h48;
`ifdef I2C_CLK_STRETCH_EN
    localparam int STR = 10;
`else
    localparam int STR = 0;
`endif

    logic       clk = 1'b0, rst = 1'b1, start_req = 1'b0, rw = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] rd_data;
    logic       busy, done, nack, SCL, SDA_out, SDA_in, SCL_in;

    int         cyc = 0, checks = 0, errors = 0, n_done = 0, st_lo = -1, st_hi = -1, bitno = 99;
    logic [7:0] slv_rd = '0, hdr = '0, exp_rd = '0;
    logic       slv_dnack = 1'b0, slv_sda, scl_q = 1'b1, sda_q = 1'b1;
    logic       cap[$];

    i2c_master_ctrl #(.CLK_DIV(D)) dut (
        .clk(clk), .rst(rst), .start_req(start_req), .addr(addr), .rw(rw), .wr_data(wr_data),
        .rd_data(rd_data), .busy(busy), .done(done), .nack(nack),
        .SCL(SCL), .SDA_out(SDA_out), .SDA_in(SDA_in), .SCL_in(SCL_in)
    );

    always #5 clk = ~clk;

    assign SDA_in = SDA_out & slv_sda;
    assign SCL_in = SCL & !(cyc >= st_lo && cyc < st_hi);

    // Bus monitor: bitno = index of the SCL-low..high bit slot since the last START.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        scl_q <= SCL;
        sda_q <= SDA_in;
        if (done) n_done <= n_done + 1;
        if (SCL && scl_q && sda_q && !SDA_in) begin
            bitno <= -1;
            cap.delete();
        end else if (SCL && scl_q && !sda_q && SDA_in) bitno <= 99;
        else if (!SCL && scl_q) bitno <= bitno + 1;
        if (SCL && !scl_q && bitno >= 0 && bitno < 99) begin
            cap.push_back(SDA_in);
            if (bitno < 8) hdr <= {hdr[6:0], SDA_in};
        end
    end

    // Single-byte slave at SLV: ACKs its address, serves slv_rd, ACK/NACKs written data.
    always_comb begin
        slv_sda = 1'b1;
        if (hdr[7:1] == SLV && bitno == 8) slv_sda = 1'b0;
        else if (hdr[7:1] == SLV && hdr[0] && bitno >= 9 && bitno <= 16) slv_sda = slv_rd[3'(16 - bitno)];
        else if (hdr[7:1] == SLV && !hdr[0] && bitno == 17) slv_sda = slv_dnack;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic txn(input logic [6:0] a, input logic r, input logic [7:0] w, input bit str, input bit pulse);
        int          t0, nd, n;
        bit          m;
        logic [18:0] e, got;
        m = a == SLV;
        // every SCL rise after START: addr, rw, ack, data, ack, then the STOP rise (SDA low)
        e = m ? {a, r, 1'b0, r ? slv_rd : w, r ? 1'b1 : slv_dnack, 1'b0} : 19'({a, r, 1'b1, 1'b0});
        n = m ? 19 : 10;
        @(negedge clk);
        addr = a; rw = r; wr_data = w; start_req = 1'b1;
        t0 = cyc;
        nd = n_done;
        if (str) begin
            st_lo = t0 + 1 + 22 * D;
            st_hi = st_lo + 10;
        end
        @(negedge clk);
        start_req = 1'b0;
        chk("busy", busy, 1);
        while (!done && cyc - t0 < 2000) begin
            @(negedge clk);
            start_req = pulse && (cyc - t0 == 50);
            addr = start_req ? ~a : a;
            rw = start_req ? ~r : r;
        end
        start_req = 1'b0;
        chk("done_lat", cyc - t0, (m ? 80 * D : 44 * D) + 1 + (str ? STR : 0));
        chk("busy_done", busy, 0);
        chk("nack", nack, !m || (!r && slv_dnack));
        if (m && r) exp_rd = slv_rd;
        chk("rd_data", rd_data, exp_rd);
        got = '0;
        foreach (cap[i]) got = {got[17:0], cap[i]};
        chk("nbits", cap.size(), n);
        chk("bits", got, e);
        @(negedge clk);
        chk("done_low", done, 0);
        chk("n_done", n_done - nd, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_scl", SCL, 1);
        chk("rst_sda", SDA_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_nack", nack, 0);
        chk("rst_rd", rd_data, 0);
        rst = 1'b0;
        txn(SLV, 1'b0, 8'hA5, 1'b0, 1'b0);
        txn(7'h21, 1'b0, 8'hA5, 1'b0, 1'b0);
        slv_rd = 8'h3C;
        txn(SLV, 1'b1, 8'h00, 1'b0, 1'b0);
        txn(SLV, 1'b0, 8'h6B, 1'b0, 1'b1);
        slv_dnack = 1'b1;
        txn(SLV, 1'b0, 8'h81, 1'b0, 1'b0);
        slv_dnack = 1'b0;
        @(negedge clk);
        addr = SLV; rw = 1'b0; wr_data = 8'h5A; start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        for (int i = 0; i < 2000 && bitno != 13; i++) @(negedge clk);
        chk("rst_reach", bitno, 13);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_scl", SCL, 1);
        chk("mid_sda", SDA_out, 1);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_rd", rd_data, 0);
        rst = 1'b0;
        exp_rd = '0;
        txn(SLV, 1'b0, 8'hC3, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            logic [6:0] a;
            a = $urandom_range(0, 1) ? SLV : 7'($urandom);
            slv_rd = 8'($urandom);
            slv_dnack = 1'($urandom_range(0, 1));
            txn(a, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0);
        end
        slv_dnack = 1'b0;
        txn(SLV, 1'b0, 8'hA5, 1'b1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
